// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types, constants and helpers for the kamus L1D data memory
//   l1d_state_e : sequencer state (zero-fill, then normal operation)
//   be_merge    : byte-lane merge of a new word into an old word
package kamus_pkg;

    typedef enum logic {L1D_CLEAR, L1D_RUN} l1d_state_e;

    localparam int          L1D_WORD_BYTES = 4;
    localparam logic [3:0]  L1D_BE_FULL    = 4'hF;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < L1D_WORD_BYTES; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/kamus_ram_1w1r.sv
// kamus_ram_1w1r: word RAM, synchronous byte-enabled write, asynchronous read
//   clk   : write clock
//   we    : write strobe, wbe selects the lanes written at the rising edge
//   waddr : write word index, wdata : write word
//   raddr : read word index, rdata : combinational read word (old value on collision)
module kamus_ram_1w1r
    import kamus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= be_merge(mem[waddr], wdata, wbe);

    assign rdata = mem[raddr];

endmodule

// File: rtl/kamus_l1d_mem.sv
// kamus_l1d_mem: single-cycle L1D data memory with zero-fill, back-door loader,
// sticky out-of-range error and committed-store counter
//   clk_i, rst_i                      : clock, async active-high reset
//   l1d_wr_en_i/addr_i/wr_data_i/be_i : core store / read request
//   l1d_rd_data_o                     : combinational read data (0 out of range or while clearing)
//   ld_valid_i/ld_addr_i/ld_data_i    : loader full-word write request
//   ld_ready_o                        : loader accepted (core has priority)
//   init_done_o                       : zero-fill finished
//   err_o                             : sticky out-of-range access flag
//   wr_cnt_o                          : committed core stores, wrapping
module kamus_l1d_mem
    import kamus_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic        CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        l1d_wr_en_i,
    input  logic [31:0] l1d_addr_i,
    input  logic [31:0] l1d_wr_data_i,
    input  logic [3:0]  l1d_be_i,
    output logic [31:0] l1d_rd_data_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    output logic        init_done_o,
    output logic        err_o,
    output logic [31:0] wr_cnt_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    l1d_state_e  state, state_d;
    logic [AW-1:0] clr_idx;
    logic [31:0] core_w, ld_w, ram_rd, wdata;
    logic [AW-1:0] waddr;
    logic [3:0]  wbe;
    logic        run, clearing, core_in, ld_in, core_we, ld_fire, ld_we, we;

    // Word index of each port; full 32-bit compare so wrapped offsets stay out of range
    assign core_w   = (l1d_addr_i - BASE_ADDR) >> 2;
    assign ld_w     = (ld_addr_i - BASE_ADDR) >> 2;
    assign core_in  = core_w < 32'(DEPTH_WORDS);
    assign ld_in    = ld_w < 32'(DEPTH_WORDS);

    assign run      = state == L1D_RUN;
    assign clearing = state == L1D_CLEAR;
    assign ld_ready_o = run && !l1d_wr_en_i;
    assign ld_fire  = ld_valid_i && ld_ready_o;
    assign core_we  = run && l1d_wr_en_i && core_in;
    assign ld_we    = ld_fire && ld_in;

    // Write-port mux: clear, then core, then loader. Held off while reset is asserted.
    assign we    = !rst_i && (clearing || core_we || ld_we);
    assign waddr = clearing ? clr_idx : core_we ? core_w[AW-1:0] : ld_w[AW-1:0];
    assign wdata = clearing ? 32'h0 : core_we ? l1d_wr_data_i : ld_data_i;
    assign wbe   = (!clearing && core_we) ? l1d_be_i : L1D_BE_FULL;

    kamus_ram_1w1r #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk_i),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .wbe   (wbe),
        .raddr (core_w[AW-1:0]),
        .rdata (ram_rd)
    );

    assign l1d_rd_data_o = (run && core_in) ? ram_rd : 32'h0;
    assign init_done_o   = run;

    always_comb begin
        state_d = state;
        if (clearing && clr_idx == AW'(DEPTH_WORDS - 1)) state_d = L1D_RUN;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= CLEAR_ON_RESET ? L1D_CLEAR : L1D_RUN;
            clr_idx  <= '0;
            err_o    <= 1'b0;
            wr_cnt_o <= 32'h0;
        end else begin
            state <= state_d;
            if (clearing) clr_idx <= clr_idx + 1'b1;
            if (run && ((l1d_wr_en_i && !core_in) || (ld_fire && !ld_in))) err_o <= 1'b1;
            if (core_we) wr_cnt_o <= wr_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_kamus_l1d_mem.sv
// tb_kamus_l1d_mem: directed plus randomized check of kamus_l1d_mem against a word-array model
module tb_kamus_l1d_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        l1d_wr_en_i;
    logic [31:0] l1d_addr_i, l1d_wr_data_i;
    logic [3:0]  l1d_be_i;
    logic [31:0] l1d_rd_data_o;
    logic        ld_valid_i, ld_ready_o;
    logic [31:0] ld_addr_i, ld_data_i;
    logic        init_done_o, err_o;
    logic [31:0] wr_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_m [16];
    logic        err_m;
    logic [31:0] cnt_m;

    always #5 clk_i = ~clk_i;

    kamus_l1d_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .l1d_wr_en_i   (l1d_wr_en_i),
        .l1d_addr_i    (l1d_addr_i),
        .l1d_wr_data_i (l1d_wr_data_i),
        .l1d_be_i      (l1d_be_i),
        .l1d_rd_data_o (l1d_rd_data_o),
        .ld_valid_i    (ld_valid_i),
        .ld_ready_o    (ld_ready_o),
        .ld_addr_i     (ld_addr_i),
        .ld_data_i     (ld_data_i),
        .init_done_o   (init_done_o),
        .err_o         (err_o),
        .wr_cnt_o      (wr_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int w;
        w = int'(a / 4);
        if (a < 32'd64) return mem_m[w];
        return 32'h0;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        err_m = 1'b0;
        cnt_m = 32'h0;
    endtask

    // Reset released at a falling edge; returns the number of rising edges until init_done
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done_o && cycles < 40) begin
            @(posedge clk_i);
            #1;
            cycles++;
            if (!init_done_o && ld_ready_o !== 1'b0) chk("ld_ready_during_clear", ld_ready_o, 0);
        end
    endtask

    task automatic rd_chk(input logic [31:0] a, input string tag);
        @(negedge clk_i);
        l1d_wr_en_i = 1'b0;
        l1d_addr_i  = a;
        #1;
        chk(tag, l1d_rd_data_o, model_rd(a));
    endtask

    task automatic core_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] old_w;
        @(negedge clk_i);
        l1d_wr_en_i = 1'b1;
        l1d_addr_i = a;
        l1d_wr_data_i = d;
        l1d_be_i = be;
        #1;
        chk("rd_before_write", l1d_rd_data_o, model_rd(a));
        @(posedge clk_i);
        if (a < 32'd64) begin
            old_w = mem_m[a / 4];
            for (int b = 0; b < 4; b++)
                if (be[b]) old_w[8*b +: 8] = d[8*b +: 8];
            mem_m[a / 4] = old_w;
            cnt_m++;
        end else begin
            err_m = 1'b1;
        end
        @(negedge clk_i);
        l1d_wr_en_i = 1'b0;
    endtask

    task automatic ld_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        l1d_wr_en_i = 1'b0;
        ld_valid_i = 1'b1;
        ld_addr_i = a;
        ld_data_i = d;
        #1;
        chk("ld_ready_idle", ld_ready_o, 1);
        @(posedge clk_i);
        if (a < 32'd64) mem_m[a / 4] = d;
        else err_m = 1'b1;
        @(negedge clk_i);
        ld_valid_i = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        #1;
        chk({tag, "_err"}, {31'h0, err_o}, {31'h0, err_m});
        chk({tag, "_cnt"}, wr_cnt_o, cnt_m);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] a, d;
        rst_i = 1'b1;
        l1d_wr_en_i = 1'b0;
        l1d_addr_i = 32'h20;
        l1d_wr_data_i = 32'h0;
        l1d_be_i = 4'hF;
        ld_valid_i = 1'b0;
        ld_addr_i = 32'h0;
        ld_data_i = 32'h0;
        zero_model();
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_init_done", {31'h0, init_done_o}, 0);
        chk("rst_err", {31'h0, err_o}, 0);
        chk("rst_cnt", wr_cnt_o, 0);
        chk("rst_ld_ready", {31'h0, ld_ready_o}, 0);
        chk("rst_rd", l1d_rd_data_o, 0);

        @(negedge clk_i);
        rst_i = 1'b0;
        wait_init(cyc);
        chk("init_cycles", cyc, 16);
        rd_chk(32'h20, "rd_20_after_clear");
        chk("rd_20_zero", l1d_rd_data_o, 0);

        ld_wr(32'h4, 32'h0111_111F);
        for (int i = 4; i < 8; i++) begin
            rd_chk(32'(i), "rd_loaded_word");
            chk("rd_loaded_const", l1d_rd_data_o, 32'h0111_111F);
        end

        ld_wr(32'h8, 32'h1122_3344);
        core_wr(32'h8, 32'hAABB_CCDD, 4'h3);
        rd_chk(32'h8, "rd_be_merge");
        chk("rd_be_merge_const", l1d_rd_data_o, 32'h1122_CCDD);
        chk("cnt_after_one_store", wr_cnt_o, 1);

        // Core and loader collide on the same word
        @(negedge clk_i);
        l1d_wr_en_i = 1'b1;
        l1d_addr_i = 32'hC;
        l1d_wr_data_i = 32'hCAFE_0001;
        l1d_be_i = 4'hF;
        ld_valid_i = 1'b1;
        ld_addr_i = 32'hC;
        ld_data_i = 32'h0BAD_0002;
        #1;
        chk("collide_ld_ready_low", {31'h0, ld_ready_o}, 0);
        @(posedge clk_i);
        mem_m[3] = 32'hCAFE_0001;
        cnt_m++;
        @(negedge clk_i);
        l1d_wr_en_i = 1'b0;
        #1;
        chk("collide_ld_ready_high", {31'h0, ld_ready_o}, 1);
        chk("collide_core_data", l1d_rd_data_o, 32'hCAFE_0001);
        @(posedge clk_i);
        mem_m[3] = 32'h0BAD_0002;
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        #1;
        chk("collide_loader_data", l1d_rd_data_o, 32'h0BAD_0002);

        core_wr(32'h40, 32'hDEAD_BEEF, 4'hF);
        chk_status("oor_core");
        chk("oor_err_const", {31'h0, err_o}, 1);
        chk("oor_cnt_const", wr_cnt_o, 2);
        rd_chk(32'h40, "oor_rd");
        chk("oor_rd_zero", l1d_rd_data_o, 0);
        core_wr(32'h10, 32'h5555_AAAA, 4'h0);
        chk_status("be_zero");

        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 32'h4F);
            d = $urandom;
            case ($urandom_range(0, 2))
                0: core_wr(a, d, 4'($urandom_range(0, 15)));
                1: ld_wr(a, d);
                default: rd_chk(a, "rand_rd");
            endcase
            if (n % 10 == 0) chk_status("rand");
        end
        for (int i = 0; i < 16; i++) rd_chk(32'(4 * i), "rand_final_rd");
        chk_status("rand_final");

        // Reset pulsed mid-clear restarts the sequence from word 0
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        zero_model();
        wait_init(cyc);
        chk("reinit_cycles", cyc, 16);
        @(negedge clk_i);
        chk_status("reinit");
        for (int i = 0; i < 16; i++) rd_chk(32'(4 * i), "reinit_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
